// File: rtl/gain_saturate_stage_pkg.sv
// Shared constants and helpers for the gain/saturation datapath.
// Parameter-dependent values are computed here so every scaling stage derives them the same way.
package gain_saturate_stage_pkg;

  function automatic longint out_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint out_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  // Half an LSB of the output grid; added before the shift so rounding is half-up.
  function automatic longint round_const(input int shift);
    return longint'(1) << (shift - 1);
  endfunction

  function automatic longint unity_gain(input int shift);
    return longint'(1) << shift;
  endfunction

endpackage

// File: rtl/gain_saturate_stage_sat_round_shift.sv
// Combinational round-half-up, arithmetic right shift and clamp to a signed output width.
// The clip flag marks inputs whose rounded value fell outside the output range.
module sat_round_shift
  import gain_saturate_stage_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int SHIFT = 16,
  parameter int OUT_W = 14
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o,
  output logic             clip_o
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int EW = IN_W + 1;
  localparam logic signed [EW-1:0] RND = EW'(round_const(SHIFT));
  localparam logic signed [EW-1:0] HI  = EW'(out_max(OUT_W));
  localparam logic signed [EW-1:0] LO  = EW'(out_min(OUT_W));

  logic signed [EW-1:0] sum_w;
  logic signed [EW-1:0] shr_w;

  always_comb begin
    sum_w  = $signed({in_i[IN_W-1], in_i}) + RND;
    shr_w  = sum_w >>> SHIFT;
    clip_o = 1'b0;
    out_o  = shr_w[OUT_W-1:0];
    if (shr_w > HI) begin
      clip_o = 1'b1;
      out_o  = HI[OUT_W-1:0];
    end else if (shr_w < LO) begin
      clip_o = 1'b1;
      out_o  = LO[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/gain_saturate_stage.sv
// Three-stage signed gain: register, full-precision multiply, round/shift/saturate.
// Tracks clipped samples with a sticky flag and a saturating event counter.
module gain_saturate_stage
  import gain_saturate_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_WIDTH = 32,
  parameter int SHIFT      = 16,
  parameter int OUT_WIDTH  = 14,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic [GAIN_WIDTH-1:0] gain_i,
  input  logic                  gain_load_i,
  input  logic                  clr_i,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  valid_o,
  output logic                  sat_o,
  output logic [CNT_WIDTH-1:0]  sat_cnt_o
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH;
  localparam logic [GAIN_WIDTH-1:0] UNITY   = GAIN_WIDTH'(unity_gain(SHIFT));
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [GAIN_WIDTH-1:0] s1_gain_q, s1_gain_d;
  logic [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic [PW-1:0]         prod_q, prod_d;
  logic [OUT_WIDTH-1:0]  data_q, data_d;
  logic [2:0]            vld_pipe_q, vld_pipe_d;
  logic                  sat_q, sat_d;
  logic [CNT_WIDTH-1:0]  sat_cnt_q, sat_cnt_d;

  logic [OUT_WIDTH-1:0]  rnd_data_w;
  logic                  clip_w;
  logic                  clip_evt_w;

  sat_round_shift #(
    .IN_W  (PW),
    .SHIFT (SHIFT),
    .OUT_W (OUT_WIDTH)
  ) u_sat_round_shift (
    .in_i   (prod_q),
    .out_o  (rnd_data_w),
    .clip_o (clip_w)
  );

  always_comb begin
    s1_data_d  = data_i;
    // The gain travels with its sample, so a load on the same edge doesn't affect it.
    s1_gain_d  = gain_q;
    gain_d     = gain_load_i ? gain_i : gain_q;
    vld_pipe_d = {vld_pipe_q[1:0], valid_i};
    prod_d     = $signed({{GAIN_WIDTH{s1_data_q[DATA_WIDTH-1]}}, s1_data_q}) *
                 $signed({{DATA_WIDTH{s1_gain_q[GAIN_WIDTH-1]}}, s1_gain_q});
    data_d     = vld_pipe_q[1] ? rnd_data_w : data_q;
    clip_evt_w = vld_pipe_q[1] & clip_w;
    sat_d      = sat_q;
    sat_cnt_d  = sat_cnt_q;
    if (clr_i) begin
      sat_d     = 1'b0;
      sat_cnt_d = '0;
    end else if (clip_evt_w) begin
      sat_d = 1'b1;
      if (sat_cnt_q != CNT_MAX) sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_data_q  <= '0;
      s1_gain_q  <= '0;
      gain_q     <= UNITY;
      prod_q     <= '0;
      data_q     <= '0;
      vld_pipe_q <= '0;
      sat_q      <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_gain_q  <= s1_gain_d;
      gain_q     <= gain_d;
      prod_q     <= prod_d;
      data_q     <= data_d;
      vld_pipe_q <= vld_pipe_d;
      sat_q      <= sat_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = vld_pipe_q[2];
  assign sat_o     = sat_q;
  assign sat_cnt_o = sat_cnt_q;

endmodule
